// File: rtl/jednostka_sterujaca.sv
// Fetch/decode/execute sequencer for the 8-bit PLC core: owns the PC, latches the
// 16-bit instruction word from the ROM and issues one-cycle datapath strobes.
module jednostka_sterujaca #(
    parameter logic [7:0]  RESET_VEC = 8'd0,
    parameter int unsigned PTIMEOUT  = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       step,
    input  logic       err_clr,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_dane,
    input  logic [7:0] rom_wartosc,
    output logic [7:0] operand,
    output logic [1:0] src_sel,
    output logic [1:0] alu_op,
    output logic       acc_we,
    output logic       r_we,
    output logic       p_req,
    output logic       p_we,
    input  logic       p_ack,
    output logic       busy,
    output logic       illegal,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WAIT_P = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(PTIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        illegal_q, illegal_d;
    logic        timeout_q, timeout_d;

    logic [3:0]  opc;
    logic        hi_ok;
    state_t      after_insn;

    assign opc        = ir_q[11:8];
    assign hi_ok      = (ir_q[15:12] == 4'h0);
    assign after_insn = run ? ST_FETCH : ST_IDLE;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        src_sel   = 2'b00;
        alu_op    = 2'b00;
        acc_we    = 1'b0;
        r_we      = 1'b0;
        p_req     = 1'b0;
        p_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run || step) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ir_d    = {rom_dane, rom_wartosc};
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                pc_d    = pc_q + 8'd1;
                state_d = after_insn;
                cnt_d   = 8'd0;
                if (!hi_ok) begin
                    illegal_d = 1'b1;
                end else begin
                    case (opc)
                        4'hC: ;
                        4'hD: acc_we = 1'b1;
                        4'h5: begin
                            src_sel = 2'b10;
                            alu_op  = 2'b01;
                            acc_we  = 1'b1;
                        end
                        4'h8: begin
                            alu_op = 2'b11;
                            acc_we = 1'b1;
                        end
                        4'h9: begin
                            alu_op = 2'b10;
                            acc_we = 1'b1;
                        end
                        4'hB: r_we = 1'b1;
                        // P accesses advance the PC only when the bus access ends
                        4'h6, 4'h7: begin
                            pc_d    = pc_q;
                            state_d = ST_WAIT_P;
                        end
                        4'hE: pc_d = ir_q[7:0];
                        4'hF: pc_d = RESET_VEC;
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            ST_WAIT_P: begin
                p_req = 1'b1;
                p_we  = (opc == 4'h6);
                if (p_ack) begin
                    if (opc == 4'h7) begin
                        src_sel = 2'b01;
                        acc_we  = 1'b1;
                    end
                    pc_d    = pc_q + 8'd1;
                    state_d = after_insn;
                end else if (cnt_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    pc_d      = pc_q + 8'd1;
                    state_d   = after_insn;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Clearing wins over a flag being raised in the same cycle
        if (err_clr) begin
            illegal_d = 1'b0;
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_VEC;
            ir_q      <= 16'd0;
            cnt_q     <= 8'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign rom_addr = pc_q;
    assign operand  = ir_q[7:0];
    assign busy     = (state_q != ST_IDLE);
    assign illegal  = illegal_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_jednostka_sterujaca.sv
// Bench for the PLC sequencer: directed ROM programs, a reactive P-bus responder
// and a scoreboard comparing strobe cycles and P-bus accesses against an expected queue.
module tb_jednostka_sterujaca;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run, step, err_clr;
    logic [7:0] rom_addr, rom_dane, rom_wartosc, operand;
    logic [1:0] src_sel, alu_op;
    logic       acc_we, r_we, p_req, p_we, p_ack;
    logic       busy, illegal, timeout;

    logic [15:0] rom_mem [0:255];
    logic [31:0] exp_q [$];
    int          addr_cycles [0:255];
    int          n_cmp = 0;
    int          n_err = 0;
    int          wcnt  = 0;
    int          plen  = 0;
    logic [7:0]  p_op;
    logic        p_dir;
    logic [7:0]  seq [0:4] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2};

    always #5 clk = ~clk;

    assign rom_dane    = rom_mem[rom_addr][15:8];
    assign rom_wartosc = rom_mem[rom_addr][7:0];

    jednostka_sterujaca #(.RESET_VEC(8'd0), .PTIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .err_clr(err_clr),
        .rom_addr(rom_addr), .rom_dane(rom_dane), .rom_wartosc(rom_wartosc),
        .operand(operand), .src_sel(src_sel), .alu_op(alu_op),
        .acc_we(acc_we), .r_we(r_we), .p_req(p_req), .p_we(p_we), .p_ack(p_ack),
        .busy(busy), .illegal(illegal), .timeout(timeout)
    );

    function automatic logic [31:0] ev_s(input logic [7:0] a, input logic [7:0] op,
                                         input logic [1:0] s, input logic [1:0] al,
                                         input logic aw, input logic rw);
        return {4'h1, a, op, s, al, aw, rw, 6'd0};
    endfunction

    function automatic logic [31:0] ev_p(input logic [7:0] len, input logic [7:0] op,
                                         input logic we);
        return {4'h2, len, op, we, 11'd0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_event(input logic [31:0] got);
        logic [31:0] exp;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got %h expected none", got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                n_err++;
                $display("FAIL event: got %h expected %h", got, exp);
            end
        end
    endtask

    task automatic wait_addr(input logic [7:0] a, input int maxc);
        int i;
        for (i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (rom_addr == a) break;
        end
        if (i == maxc) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_addr_%0h: rom_addr %h after %0d cycles", a, rom_addr, maxc);
        end
    endtask

    task automatic wait_idle(input int maxc);
        int i;
        for (i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (i == maxc) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: busy still %b after %0d cycles", busy, maxc);
        end
    endtask

    task automatic pulse_step();
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    // P-bus responder: ack timing chosen by the accessed address
    initial begin
        p_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (p_req) begin
                wcnt++;
                p_ack = (operand == 8'h01 && wcnt == 3) || (operand == 8'h02 && wcnt == 1);
            end else begin
                wcnt  = 0;
                p_ack = 1'b0;
            end
        end
    end

    // Monitor: strobe cycles and completed P accesses are popped against exp_q
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (busy) addr_cycles[rom_addr]++;
            if (acc_we || r_we)
                compare_event(ev_s(rom_addr, operand, src_sel, alu_op, acc_we, r_we));
            if (p_req) begin
                plen++;
                p_op  = operand;
                p_dir = p_we;
            end else if (plen != 0) begin
                compare_event(ev_p(8'(plen), p_op, p_dir));
                plen = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; step = 1'b0; err_clr = 1'b0;
        for (int i = 0; i < 256; i++) begin
            rom_mem[i]     = 16'h0C00;
            addr_cycles[i] = 0;
        end
        rom_mem[0]  = 16'h0C00; rom_mem[1]  = 16'h0D07; rom_mem[2]  = 16'h0601;
        rom_mem[3]  = 16'h0702; rom_mem[4]  = 16'h0505; rom_mem[5]  = 16'h0B09;
        rom_mem[6]  = 16'h0900; rom_mem[7]  = 16'h0800; rom_mem[8]  = 16'h0A00;
        rom_mem[9]  = 16'h0C00; rom_mem[10] = 16'h0E0C; rom_mem[11] = 16'h0D55;
        rom_mem[12] = 16'h1D00; rom_mem[13] = 16'h0C00; rom_mem[14] = 16'h0F00;

        repeat (2) @(negedge clk);
        check("rst_rom_addr", rom_addr, 8'h00);
        check("rst_operand", operand, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_p_req", p_req, 1'b0);
        check("rst_strobes", {acc_we, r_we}, 2'b00);
        check("rst_flags", {illegal, timeout}, 2'b00);

        exp_q.push_back(ev_s(8'h01, 8'h07, 2'b00, 2'b00, 1'b1, 1'b0));
        exp_q.push_back(ev_p(8'd3, 8'h01, 1'b1));
        exp_q.push_back(ev_s(8'h03, 8'h02, 2'b01, 2'b00, 1'b1, 1'b0));
        exp_q.push_back(ev_p(8'd1, 8'h02, 1'b0));
        exp_q.push_back(ev_s(8'h04, 8'h05, 2'b10, 2'b01, 1'b1, 1'b0));
        exp_q.push_back(ev_s(8'h05, 8'h09, 2'b00, 2'b00, 1'b0, 1'b1));
        exp_q.push_back(ev_s(8'h06, 8'h00, 2'b00, 2'b10, 1'b1, 1'b0));
        exp_q.push_back(ev_s(8'h07, 8'h00, 2'b00, 2'b11, 1'b1, 1'b0));

        run = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("fetch_seq_%0d", i), rom_addr, seq[i]);
        end
        check("flags_early", {illegal, timeout}, 2'b00);

        wait_addr(8'd14, 100);
        run = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_insn_pc", rom_addr, 8'h00);
        check("run_off_idle", busy, 1'b0);
        check("illegal_set", illegal, 1'b1);
        check("no_timeout", timeout, 1'b0);
        check("st_p_cycles", addr_cycles[2], 5);
        check("ld_p_cycles", addr_cycles[3], 3);
        check("nop_cycles", addr_cycles[0], 2);
        check("jmp_cycles", addr_cycles[10], 2);
        check("jmp_skipped", addr_cycles[11], 0);
        check("jmp_target", addr_cycles[12], 2);

        // Step mode, P timeouts, flag clearing and PC wrap
        rom_mem[0] = 16'h0603; rom_mem[1] = 16'h0703; rom_mem[2] = 16'h0D21;
        rom_mem[3] = 16'h0EFF; rom_mem[255] = 16'h0900;
        for (int i = 0; i < 256; i++) addr_cycles[i] = 0;

        exp_q.push_back(ev_p(8'd15, 8'h03, 1'b1));
        pulse_step();
        repeat (4) @(negedge clk);
        pulse_step();
        wait_idle(40);
        check("tmo_flag", timeout, 1'b1);
        check("tmo_pc", rom_addr, 8'h01);
        check("tmo_cycles", addr_cycles[0], 17);

        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr_flags", {illegal, timeout}, 2'b00);

        err_clr = 1'b1;
        exp_q.push_back(ev_p(8'd15, 8'h03, 1'b0));
        pulse_step();
        wait_idle(40);
        check("clr_priority", timeout, 1'b0);
        check("ld_tmo_pc", rom_addr, 8'h02);
        err_clr = 1'b0;

        exp_q.push_back(ev_s(8'h02, 8'h21, 2'b00, 2'b00, 1'b1, 1'b0));
        pulse_step();
        wait_idle(10);
        check("step_pc", rom_addr, 8'h03);
        check("step_idle", busy, 1'b0);

        pulse_step();
        wait_idle(10);
        check("jmp_ff", rom_addr, 8'hFF);
        exp_q.push_back(ev_s(8'hFF, 8'h00, 2'b00, 2'b10, 1'b1, 1'b0));
        pulse_step();
        wait_idle(10);
        check("pc_wrap", rom_addr, 8'h00);

        // Asynchronous reset in the middle of a P access
        rom_mem[0] = 16'h0E05; rom_mem[5] = 16'h0603;
        pulse_step();
        wait_idle(10);
        check("jmp_5", rom_addr, 8'h05);
        exp_q.push_back(ev_p(8'd3, 8'h03, 1'b1));
        pulse_step();
        begin
            int i;
            for (i = 0; i < 10; i++) begin
                @(negedge clk);
                if (p_req) break;
            end
            if (i == 10) begin
                n_cmp++;
                n_err++;
                $display("FAIL wait_p_req: p_req %b after 10 cycles", p_req);
            end
        end
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_wait_p_req", p_req, 1'b0);
        check("rst_wait_addr", rom_addr, 8'h00);
        check("rst_wait_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
